// File: rtl/motor_spin_ctrl.sv
// motor_spin_ctrl: start/run sequencer for the scan motor and its read-head decoder.
// Spins the motor up, qualifies speed lock from the averaged period, retries on stall/timeout.
module motor_spin_ctrl #(
    parameter logic [31:0] SPINUP_TIMEOUT = 32'd200_000_000,
    parameter logic [31:0] RETRY_WAIT     = 32'd50_000_000,
    parameter logic [3:0]  LOCK_REVS      = 4'd8,
    parameter logic [3:0]  UNLOCK_REVS    = 4'd2,
    parameter logic [3:0]  MAX_RETRY      = 4'd3,
    parameter int          TOL_SHIFT      = 5,
    parameter int          AVG_LAT        = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic        i_fault_clr,
    input  logic        i_real_zero_flag,
    input  logic        i_motor_block,
    input  logic [31:0] i_cycle_cnt,
    input  logic [31:0] i_target_cycle,
    output logic        o_motor_enable,
    output logic        o_motor_ready,
    output logic        o_motor_fault,
    output logic [2:0]  o_state,
    output logic [3:0]  o_retry_cnt
);

    // state  | meaning
    // IDLE   | motor off, waiting for start
    // SPINUP | motor on, waiting for the first physical zero
    // LOCK   | counting consecutive in-tolerance revolutions
    // RUN    | speed locked, motor_ready high
    // RETRY  | motor off dwell before the next attempt
    // FAULT  | sticky fault, waiting for fault_clr
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SPINUP = 3'd1,
        ST_LOCK   = 3'd2,
        ST_RUN    = 3'd3,
        ST_RETRY  = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_retry_cnt;
    logic [3:0]         w_retry_nxt;
    logic [3:0]         r_lock_cnt;
    logic [3:0]         w_lock_nxt;
    logic [3:0]         r_miss_cnt;
    logic [3:0]         w_miss_nxt;
    logic [31:0]        r_att_tmr;
    logic [31:0]        w_att_nxt;
    logic [31:0]        r_wait_tmr;
    logic [31:0]        w_wait_nxt;
    logic [AVG_LAT-1:0] r_zf_dly;
    logic               r_motor_enable;
    logic               r_motor_ready;
    logic               r_motor_fault;
    logic               w_chk;
    logic               w_good;
    logic               w_fail_evt;
    logic [32:0]        w_err;
    logic [32:0]        w_tol;
    logic [4:0]         w_lock_inc;
    logic [4:0]         w_miss_inc;

    assign w_chk      = r_zf_dly[AVG_LAT-1];
    assign w_err      = (i_cycle_cnt >= i_target_cycle) ?
                        ({1'b0, i_cycle_cnt} - {1'b0, i_target_cycle}) :
                        ({1'b0, i_target_cycle} - {1'b0, i_cycle_cnt});
    assign w_tol      = {1'b0, i_target_cycle >> TOL_SHIFT};
    assign w_good     = (w_err <= w_tol);
    assign w_lock_inc = {1'b0, r_lock_cnt} + 5'd1;
    assign w_miss_inc = {1'b0, r_miss_cnt} + 5'd1;

    // Attempt timer is a down-counter: loaded on SPINUP entry, expired at zero.
    always_comb begin
        w_fail_evt = 1'b0;
        case (r_state)
            ST_SPINUP, ST_LOCK: w_fail_evt = i_motor_block | (r_att_tmr == 32'd0);
            ST_RUN:             w_fail_evt = i_motor_block;
            default:            w_fail_evt = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry_cnt;
        w_lock_nxt  = r_lock_cnt;
        w_miss_nxt  = r_miss_cnt;
        w_wait_nxt  = r_wait_tmr;
        w_att_nxt   = r_att_tmr;
        if ((r_state == ST_SPINUP || r_state == ST_LOCK) && r_att_tmr != 32'd0)
            w_att_nxt = r_att_tmr - 32'd1;

        if (i_stop) begin
            w_state_nxt = ST_IDLE;
            w_retry_nxt = 4'd0;
            w_lock_nxt  = 4'd0;
            w_miss_nxt  = 4'd0;
        end else if (w_fail_evt) begin
            if (r_retry_cnt < MAX_RETRY) begin
                w_state_nxt = ST_RETRY;
                w_retry_nxt = r_retry_cnt + 4'd1;
                w_wait_nxt  = RETRY_WAIT - 32'd1;
            end else begin
                w_state_nxt = ST_FAULT;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        w_state_nxt = ST_SPINUP;
                        w_retry_nxt = 4'd0;
                        w_att_nxt   = SPINUP_TIMEOUT - 32'd1;
                    end
                end
                ST_SPINUP: begin
                    if (i_real_zero_flag) begin
                        w_state_nxt = ST_LOCK;
                        w_lock_nxt  = 4'd0;
                    end
                end
                ST_LOCK: begin
                    if (w_chk) begin
                        if (w_good) begin
                            w_lock_nxt = (r_lock_cnt == 4'hF) ? 4'hF : w_lock_inc[3:0];
                            if (w_lock_inc >= {1'b0, LOCK_REVS}) begin
                                w_state_nxt = ST_RUN;
                                w_retry_nxt = 4'd0;
                                w_miss_nxt  = 4'd0;
                            end
                        end else begin
                            w_lock_nxt = 4'd0;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_chk) begin
                        if (w_good) begin
                            w_miss_nxt = 4'd0;
                        end else if (w_miss_inc >= {1'b0, UNLOCK_REVS}) begin
                            w_state_nxt = ST_LOCK;
                            w_lock_nxt  = 4'd0;
                            w_miss_nxt  = 4'd0;
                        end else begin
                            w_miss_nxt = (r_miss_cnt == 4'hF) ? 4'hF : w_miss_inc[3:0];
                        end
                    end
                end
                ST_RETRY: begin
                    if (r_wait_tmr == 32'd0) begin
                        w_state_nxt = ST_SPINUP;
                        w_att_nxt   = SPINUP_TIMEOUT - 32'd1;
                    end else begin
                        w_wait_nxt = r_wait_tmr - 32'd1;
                    end
                end
                ST_FAULT: begin
                    if (i_fault_clr) begin
                        w_state_nxt = ST_IDLE;
                        w_retry_nxt = 4'd0;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_retry_cnt    <= 4'd0;
            r_lock_cnt     <= 4'd0;
            r_miss_cnt     <= 4'd0;
            r_att_tmr      <= 32'd0;
            r_wait_tmr     <= 32'd0;
            r_zf_dly       <= '0;
            r_motor_enable <= 1'b0;
            r_motor_ready  <= 1'b0;
            r_motor_fault  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_retry_cnt    <= w_retry_nxt;
            r_lock_cnt     <= w_lock_nxt;
            r_miss_cnt     <= w_miss_nxt;
            r_att_tmr      <= w_att_nxt;
            r_wait_tmr     <= w_wait_nxt;
            r_zf_dly       <= (r_zf_dly << 1) | AVG_LAT'(i_real_zero_flag);
            r_motor_enable <= (w_state_nxt == ST_SPINUP) || (w_state_nxt == ST_LOCK) ||
                              (w_state_nxt == ST_RUN);
            r_motor_ready  <= (w_state_nxt == ST_RUN);
            r_motor_fault  <= (w_state_nxt == ST_FAULT);
        end
    end

    assign o_motor_enable = r_motor_enable;
    assign o_motor_ready  = r_motor_ready;
    assign o_motor_fault  = r_motor_fault;
    assign o_state        = r_state;
    assign o_retry_cnt    = r_retry_cnt;

endmodule
